beat_sequencer: RTL and testbench



---
 rtl/beat_pkg.sv | 17 +
 rtl/beat_sequencer_step_timer.sv | 42 ++++
 rtl/beat_sequencer.sv | 122 ++++++++++++
 tb/tb_beat_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/beat_pkg.sv
// rtl/beat_pkg.sv - shared chart/lane constants and sequencer state type
package beat_pkg;

    localparam int LANES       = 4;
    localparam int CHART_DEPTH = 600;
    localparam int ADDR_W      = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_RD,
        S_EMIT,
        S_PAUSE,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/beat_sequencer_step_timer.sv
// rtl/beat_sequencer_step_timer.sv - step divider; tick marks the last cycle of a chart step
module step_timer #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic load2,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] TWO  = CW'(2);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    // load2 pre-charges the count to absorb the RD and EMIT cycles of each step
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load2) begin
            cnt_d = TWO;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/beat_sequencer.sv
// rtl/beat_sequencer.sv - plays the note chart: fetch one word per step, emit lane mask pulses
module beat_sequencer
    import beat_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int STEP_US  = 100_000,
    parameter int TICK_DIV = CLK_FREQ / 1_000_000 * STEP_US,
    parameter int DEPTH    = CHART_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pause,
    input  logic              stop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [LANES-1:0]  rom_data,
    output logic              note_valid,
    output logic [LANES-1:0]  note_lanes,
    output logic [ADDR_W-1:0] step_idx,
    output logic              playing,
    output logic              paused,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_STEP = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] STEP_ONE  = ADDR_W'(1);

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] step_q, step_d;
    logic [LANES-1:0]  lanes_q, lanes_d;
    logic              tick, tmr_clr, tmr_en, tmr_load2, emit_fire;

    step_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_step_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .load2 (tmr_load2),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        tmr_clr   = 1'b0;
        tmr_en    = 1'b0;
        tmr_load2 = 1'b0;
        if (stop) begin
            state_d = S_IDLE;
            step_d  = '0;
            tmr_clr = 1'b1;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d = S_RUN;
                        step_d  = '0;
                        tmr_clr = 1'b1;
                    end
                end
                S_RUN: begin
                    if (pause) begin
                        state_d = S_PAUSE;
                    end else begin
                        tmr_en  = 1'b1;
                        state_d = tick ? S_RD : S_RUN;
                    end
                end
                // the release cycle counts as a run cycle, so the delay equals the PAUSE cycles
                S_PAUSE: begin
                    if (!pause) begin
                        tmr_en  = 1'b1;
                        state_d = tick ? S_RD : S_RUN;
                    end
                end
                S_RD: state_d = S_EMIT;
                S_EMIT: begin
                    if (step_q == LAST_STEP) begin
                        state_d = S_DONE;
                    end else begin
                        step_d    = step_q + STEP_ONE;
                        state_d   = S_RUN;
                        tmr_load2 = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // an EMIT cycle being aborted by stop or rst must not spawn notes
    always_comb begin
        emit_fire  = (state_q == S_EMIT) && !stop && !rst;
        note_valid = emit_fire && (rom_data != '0);
        note_lanes = emit_fire ? rom_data : lanes_q;
        lanes_d    = note_lanes;
    end

    always_comb begin
        rom_addr = step_q;
        step_idx = step_q;
        playing  = (state_q == S_RUN) || (state_q == S_RD) ||
                   (state_q == S_EMIT) || (state_q == S_PAUSE);
        paused   = (state_q == S_PAUSE);
        done     = (state_q == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            lanes_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            lanes_q <= lanes_d;
        end
    end

endmodule

// File: tb/tb_beat_sequencer.sv
// tb/tb_beat_sequencer.sv - randomized self-checking bench for beat_sequencer
module tb_beat_sequencer;

    localparam int TD = 4;
    localparam int DP = 8;

    logic        clk = 1'b0;
    logic        rst, start, pause, stop;
    logic [15:0] rom_addr, step_idx;
    logic [3:0]  rom_data, note_lanes;
    logic        note_valid, playing, paused, done;

    logic [3:0] chart [DP];
    int         cyc = 0;
    int         pl_cyc[$];
    logic [3:0] pl_lanes[$];
    int         paused_cnt = 0;
    int         n_pass = 0;
    int         n_total = 0;

    beat_sequencer #(
        .CLK_FREQ (1_000_000),
        .STEP_US  (TD),
        .TICK_DIV (TD),
        .DEPTH    (DP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pause      (pause),
        .stop       (stop),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .note_valid (note_valid),
        .note_lanes (note_lanes),
        .step_idx   (step_idx),
        .playing    (playing),
        .paused     (paused),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= chart[rom_addr[2:0]];
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (note_valid) begin
            pl_cyc.push_back(cyc);
            pl_lanes.push_back(note_lanes);
        end
        if (paused) paused_cnt <= paused_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic to_cyc(input int c);
        while (cyc < c) step();
    endtask

    // step k emits TD+2 cycles after start plus k whole periods; pause cycles shift later steps
    function automatic int emit_cyc(input int n, input int k, input int p, input int l);
        int c;
        c = n + TD + 2 + k * TD;
        if (l > 0 && c > p) c += l;
        return c;
    endfunction

    function automatic int nonzero_before(input int k);
        int s = 0;
        for (int i = 0; i < k; i++) if (chart[i] != 4'd0) s++;
        return s;
    endfunction

    task automatic play_song(input string name, input int pk, input int pl);
        int n, p, last, base, pbase, got_n;
        int         ex_c[$];
        logic [3:0] ex_l[$];
        base  = pl_cyc.size();
        pbase = paused_cnt;
        n = cyc;
        start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        n_total++;
        if (playing !== 1'b1 || done !== 1'b0 || rom_addr !== 16'd0 || step_idx !== 16'd0) begin
            $display("FAIL %s_start: playing=%b done=%b addr=%0d idx=%0d, want 1 0 0 0",
                     name, playing, done, rom_addr, step_idx);
        end else n_pass++;
        p = (pl > 0) ? emit_cyc(n, pk - 1, 0, 0) + 1 : 0;
        if (pl > 0) begin
            to_cyc(p);
            pause = 1'b1;
            repeat (pl) step();
            pause = 1'b0;
        end
        last = emit_cyc(n, DP - 1, p, pl);
        to_cyc(last);
        @(negedge clk);
        n_total++;
        if (done !== 1'b0) $display("FAIL %s_done_early: done=%b, want 0", name, done);
        else n_pass++;
        step();
        @(negedge clk);
        n_total++;
        if (done !== 1'b1 || playing !== 1'b0)
            $display("FAIL %s_done: done=%b playing=%b, want 1 0", name, done, playing);
        else n_pass++;
        repeat (3 * TD) step();
        @(negedge clk);
        for (int k = 0; k < DP; k++) begin
            if (chart[k] != 4'd0) begin
                ex_c.push_back(emit_cyc(n, k, p, pl));
                ex_l.push_back(chart[k]);
            end
        end
        got_n = pl_cyc.size() - base;
        n_total++;
        if (got_n !== ex_c.size())
            $display("FAIL %s_pulse_count: got %0d, want %0d", name, got_n, ex_c.size());
        else n_pass++;
        for (int i = 0; i < ex_c.size() && i < got_n; i++) begin
            n_total++;
            if (pl_cyc[base + i] !== ex_c[i] || pl_lanes[base + i] !== ex_l[i])
                $display("FAIL %s_pulse%0d: got cyc %0d lanes %h, want cyc %0d lanes %h",
                         name, i, pl_cyc[base + i] - n, pl_lanes[base + i], ex_c[i] - n, ex_l[i]);
            else n_pass++;
        end
        n_total++;
        if (paused_cnt - pbase !== pl)
            $display("FAIL %s_paused_cycles: got %0d, want %0d", name, paused_cnt - pbase, pl);
        else n_pass++;
    endtask

    task automatic check_reset_outputs(input string name);
        n_total++;
        if ({playing, paused, done, note_valid} !== 4'b0000)
            $display("FAIL %s_flags: playing/paused/done/valid=%b, want 0000", name,
                     {playing, paused, done, note_valid});
        else n_pass++;
        n_total++;
        if (rom_addr !== 16'd0 || step_idx !== 16'd0 || note_lanes !== 4'd0)
            $display("FAIL %s_data: addr=%0d idx=%0d lanes=%h, want 0 0 0", name,
                     rom_addr, step_idx, note_lanes);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check_reset_outputs("reset");
        step();
        rst = 1'b0;
    endtask

    task automatic test_stop_mid();
        int n, e4, base;
        base = pl_cyc.size();
        n = cyc;
        start = 1'b1;
        step();
        start = 1'b0;
        e4 = emit_cyc(n, 4, 0, 0);
        to_cyc(e4 - 1);
        stop = 1'b1;
        step();
        @(negedge clk);
        n_total++;
        if (note_valid !== 1'b0 || rom_addr !== 16'd0 || playing !== 1'b0)
            $display("FAIL stop_mid: valid=%b addr=%0d playing=%b, want 0 0 0",
                     note_valid, rom_addr, playing);
        else n_pass++;
        step();
        stop = 1'b0;
        repeat (2 * TD) step();
        @(negedge clk);
        n_total++;
        if (pl_cyc.size() - base !== nonzero_before(4) || playing !== 1'b0)
            $display("FAIL stop_mid_pulses: got %0d pulses playing=%b, want %0d 0",
                     pl_cyc.size() - base, playing, nonzero_before(4));
        else n_pass++;
    endtask

    task automatic test_start_stop_idle();
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        @(negedge clk);
        n_total++;
        if (playing !== 1'b0 || done !== 1'b0)
            $display("FAIL start_stop_idle: playing=%b done=%b, want 0 0", playing, done);
        else n_pass++;
    endtask

    task automatic test_start_pause_idle();
        start = 1'b1; pause = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        n_total++;
        if (playing !== 1'b1 || paused !== 1'b0)
            $display("FAIL start_pause_run: playing=%b paused=%b, want 1 0", playing, paused);
        else n_pass++;
        step();
        @(negedge clk);
        n_total++;
        if (paused !== 1'b1)
            $display("FAIL start_pause_paused: paused=%b, want 1", paused);
        else n_pass++;
        step();
        stop = 1'b1; pause = 1'b0;
        step();
        stop = 1'b0;
    endtask

    task automatic test_rst_emit();
        int n, e4, base;
        base = pl_cyc.size();
        n = cyc;
        start = 1'b1;
        step();
        start = 1'b0;
        e4 = emit_cyc(n, 4, 0, 0);
        to_cyc(e4);
        rst = 1'b1;
        @(negedge clk);
        n_total++;
        if (note_valid !== 1'b0)
            $display("FAIL rst_emit_pulse: valid=%b, want 0", note_valid);
        else n_pass++;
        step();
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_emit");
        n_total++;
        if (pl_cyc.size() - base !== nonzero_before(4))
            $display("FAIL rst_emit_pulses: got %0d, want %0d", pl_cyc.size() - base,
                     nonzero_before(4));
        else n_pass++;
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DP; i++) chart[i] = 4'($urandom);
            play_song($sformatf("random%0d", r), $urandom_range(1, DP - 1), $urandom_range(1, 12));
        end
    endtask

    initial begin
        chart[0] = 4'h1; chart[1] = 4'h0; chart[2] = 4'h3; chart[3] = 4'h0;
        chart[4] = 4'hF; chart[5] = 4'h0; chart[6] = 4'h0; chart[7] = 4'h8;
        test_reset();
        play_song("full_song", 0, 0);
        play_song("restart", 0, 0);
        play_song("pause", 2, 10);
        test_stop_mid();
        test_start_stop_idle();
        test_start_pause_idle();
        test_rst_emit();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
